// File: rtl/prbs_pkg.sv
// Shared PRBS definitions used by both the multi-bit LFSR noise generator and its checker:
// default polynomial, register length, word width, start state and the checker FSM encoding.
package prbs_pkg;

   localparam int PRBS_OUT_BITS    = 4;
   localparam int PRBS_N_BITS_REGS = 31;
   localparam logic [PRBS_N_BITS_REGS-1:0] PRBS_POLY = 31'b1001000000000000000000000000000;
   localparam logic [PRBS_N_BITS_REGS-1:0] PRBS_INITIAL_STATE = 31'h4000_0000;
   localparam int PRBS_FILL_WORDS  = (PRBS_N_BITS_REGS + PRBS_OUT_BITS - 1) / PRBS_OUT_BITS;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_t;

endpackage

// File: rtl/lfsr_step.sv
// Combinational OUT_BITS-per-step LFSR advance shared by generator and checker.
// Latency: none, pure combinational.
// Backpressure: none; the caller decides when to register the result.
module lfsr_step
   import prbs_pkg::*;
#(
   parameter int N_BITS_REGS = PRBS_N_BITS_REGS,
   parameter int OUT_BITS = PRBS_OUT_BITS,
   parameter logic [N_BITS_REGS-1:0] POLY = PRBS_POLY
) (
   input  logic [N_BITS_REGS-1:0] state_cur,
   output logic [N_BITS_REGS-1:0] state_step
);

   // Low OUT_BITS bits are the new feedback bits (oldest in the MSB), the rest shift up.
   for (genvar i = 0; i < N_BITS_REGS; i++) begin : g_bit
      if (i < OUT_BITS) begin : g_fb
         assign state_step[i] = ^(state_cur & (POLY >> (OUT_BITS - 1 - i)));
      end else begin : g_sh
         assign state_step[i] = state_cur[i - OUT_BITS];
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: lock, per-word error pulse, saturating error count.
// Latency: one accepted word to registered outputs. Backpressure: none, ena_in qualifies data.
// Optional PRBS_CHK_BIT_ERR_EN: error count accumulates bit errors instead of errored words.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int OUT_BITS = PRBS_OUT_BITS,
   parameter int N_BITS_REGS = PRBS_N_BITS_REGS,
   parameter logic [N_BITS_REGS-1:0] POLY = PRBS_POLY,
   parameter int INITIAL_STATE_SHIFT = N_BITS_REGS - 1,
   parameter int LOCK_CNT = 16,
   parameter int WIN_LEN = 256,
   parameter int LOSS_THR = 32,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 ena_in,
   input  logic [OUT_BITS-1:0]  data_in,
   input  logic                 clr_in,
   output logic                 locked_out,
   output logic                 err_out,
   output logic [ERR_CNT_W-1:0] err_cnt_out,
   output logic                 start_out
);

   localparam int FILL_WORDS = (N_BITS_REGS + OUT_BITS - 1) / OUT_BITS;
   localparam int FILL_W  = $clog2(FILL_WORDS + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = $clog2(WIN_LEN + 1);
   localparam int INC_W   = $clog2(OUT_BITS + 1);
   localparam int SUM_W   = ((ERR_CNT_W > INC_W) ? ERR_CNT_W : INC_W) + 1;
   localparam logic [N_BITS_REGS-1:0] INITIAL_STATE = N_BITS_REGS'(1) << INITIAL_STATE_SHIFT;
   localparam logic [ERR_CNT_W-1:0]   ERR_MAX = '1;

   prbs_state_t            state, state_nxt;
   logic [N_BITS_REGS-1:0] sh, sh_nxt, sh_step, sh_shift;
   logic [FILL_W-1:0]      fill_cnt, fill_cnt_nxt;
   logic [MATCH_W-1:0]     match_cnt, match_cnt_nxt;
   logic [WIN_W-1:0]       win_cnt, win_cnt_nxt;
   logic [WIN_W-1:0]       win_err, win_err_nxt, win_err_inc;
   logic [ERR_CNT_W-1:0]   err_cnt_nxt;
   logic [SUM_W-1:0]       err_sum;
   logic [INC_W-1:0]       inc;
   logic [OUT_BITS-1:0]    pred;
   logic                   mismatch;
   logic                   locked_nxt, err_nxt, start_nxt;

   lfsr_step #(
      .N_BITS_REGS (N_BITS_REGS),
      .OUT_BITS    (OUT_BITS),
      .POLY        (POLY)
   ) u_step (
      .state_cur   (sh),
      .state_step  (sh_step)
   );

   assign pred     = sh_step[OUT_BITS-1:0];
   assign mismatch = (data_in != pred);
   assign sh_shift = {sh[N_BITS_REGS-OUT_BITS-1:0], data_in};

`ifdef PRBS_CHK_BIT_ERR_EN
   always_comb begin
      inc = '0;
      for (int i = 0; i < OUT_BITS; i++) begin
         inc = inc + INC_W'(data_in[i] ^ pred[i]);
      end
   end
`else
   assign inc = INC_W'(1);
`endif

   always_comb begin
      state_nxt     = state;
      sh_nxt        = sh;
      fill_cnt_nxt  = fill_cnt;
      match_cnt_nxt = match_cnt;
      win_cnt_nxt   = win_cnt;
      win_err_nxt   = win_err;
      locked_nxt    = locked_out;
      err_nxt       = 1'b0;
      start_nxt     = 1'b0;
      err_cnt_nxt   = err_cnt_out;
      win_err_inc   = win_err + WIN_W'(mismatch);
      err_sum       = SUM_W'(err_cnt_out) + SUM_W'(inc);
      if (ena_in) begin
         case (state)
            FILL: begin
               sh_nxt = sh_shift;
               if (fill_cnt == FILL_W'(FILL_WORDS - 1)) begin
                  state_nxt     = VERIFY;
                  fill_cnt_nxt  = '0;
                  match_cnt_nxt = '0;
               end else begin
                  fill_cnt_nxt = fill_cnt + 1'b1;
               end
            end
            VERIFY: begin
               sh_nxt = sh_shift;
               if (mismatch) begin
                  state_nxt    = FILL;
                  fill_cnt_nxt = '0;
               end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                  state_nxt   = LOCKED;
                  locked_nxt  = 1'b1;
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
               end else begin
                  match_cnt_nxt = match_cnt + 1'b1;
               end
            end
            LOCKED: begin
               // Once locked the shadow free-runs so corrupted words cannot derail it.
               sh_nxt    = sh_step;
               err_nxt   = mismatch;
               start_nxt = (sh_step == INITIAL_STATE);
               if (mismatch) begin
                  err_cnt_nxt = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];
               end
               if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
                  if (win_err_inc >= WIN_W'(LOSS_THR)) begin
                     state_nxt    = FILL;
                     locked_nxt   = 1'b0;
                     fill_cnt_nxt = '0;
                  end
               end else begin
                  win_cnt_nxt = win_cnt + 1'b1;
                  win_err_nxt = win_err_inc;
               end
            end
            default: state_nxt = FILL;
         endcase
         if (clr_in) begin
            err_cnt_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= FILL;
         sh          <= '0;
         fill_cnt    <= '0;
         match_cnt   <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         locked_out  <= 1'b0;
         err_out     <= 1'b0;
         start_out   <= 1'b0;
         err_cnt_out <= '0;
      end else begin
         state       <= state_nxt;
         sh          <= sh_nxt;
         fill_cnt    <= fill_cnt_nxt;
         match_cnt   <= match_cnt_nxt;
         win_cnt     <= win_cnt_nxt;
         win_err     <= win_err_nxt;
         locked_out  <= locked_nxt;
         err_out     <= err_nxt;
         start_out   <= start_nxt;
         err_cnt_out <= err_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a bit-serial generator model feeds a default checker,
// a 4-bit-counter copy on the same inputs, and a 5-bit/1-bit-word checker for start pulses.
module tb_prbs_checker;

`ifdef PRBS_CHK_BIT_ERR_EN
   localparam int EXP_TWO = 4, EXP_LOSS = 36, EXP_HOLD = 67, EXP_AFTER_CLR = 2;
`else
   localparam int EXP_TWO = 2, EXP_LOSS = 34, EXP_HOLD = 65, EXP_AFTER_CLR = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ena, clr;
   logic [3:0]  data;
   logic        locked, err, start;
   logic [15:0] err_cnt;
   logic        sat_locked, sat_err, sat_start;
   logic [3:0]  sat_cnt;
   logic        s_rst, s_ena, s_clr;
   logic [0:0]  s_data;
   logic        s_locked, s_err, s_start;
   logic [15:0] s_cnt;

   int          n_checks = 0;
   int          n_fail = 0;
   int          since_lock = 0;
   logic [30:0] gen;
   logic [4:0]  sgen;

   prbs_checker dut (
      .clk_in(clk), .rst_in(rst), .ena_in(ena), .data_in(data), .clr_in(clr),
      .locked_out(locked), .err_out(err), .err_cnt_out(err_cnt), .start_out(start));

   prbs_checker #(.ERR_CNT_W(4)) dut_sat (
      .clk_in(clk), .rst_in(rst), .ena_in(ena), .data_in(data), .clr_in(clr),
      .locked_out(sat_locked), .err_out(sat_err), .err_cnt_out(sat_cnt), .start_out(sat_start));

   prbs_checker #(.OUT_BITS(1), .N_BITS_REGS(5), .POLY(5'b10100)) dut_small (
      .clk_in(clk), .rst_in(s_rst), .ena_in(s_ena), .data_in(s_data), .clr_in(s_clr),
      .locked_out(s_locked), .err_out(s_err), .err_cnt_out(s_cnt), .start_out(s_start));

   // x^31+x^28+1 advanced one bit at a time, four bits per word, oldest bit in the word MSB.
   task automatic send(input logic [3:0] flip, input logic clear);
      for (int k = 0; k < 4; k++) gen = {gen[29:0], gen[30] ^ gen[27]};
      data = gen[3:0] ^ flip;
      ena = 1'b1;
      clr = clear;
      @(posedge clk); #1;
      ena = 1'b0;
      clr = 1'b0;
   endtask

   task automatic ssend(input logic flip);
      sgen = {sgen[3:0], sgen[4] ^ sgen[2]};
      s_data = sgen[0] ^ flip;
      s_ena = 1'b1;
      @(posedge clk); #1;
      s_ena = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; s_rst = 1'b1; clr = 1'b0; s_clr = 1'b0;
      ena = 1'b1; data = 4'hF; s_ena = 1'b1; s_data = 1'b1;
      gen = 31'h4000_0000; sgen = 5'b10000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; s_rst = 1'b0; ena = 1'b0; s_ena = 1'b0;
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", err_cnt); end
      n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
      n_checks++; if (sat_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
      n_checks++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL reset_small_locked: got %b want 0", s_locked); end
   endtask

   task automatic test_acquire;
      int bad;
      for (int w = 1; w <= 24; w++) begin
         send(4'h0, 1'b0);
         if (w == 23) begin
            n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL no_lock_at_23: got %b want 0", locked); end
         end
      end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_at_24: got %b want 1", locked); end
      since_lock = 0;
      bad = 0;
      for (int w = 0; w < 1000; w++) begin
         send(4'h0, 1'b0);
         since_lock++;
         if (err !== 1'b0 || locked !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clean_run: %0d bad words, want 0", bad); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clean_cnt: got %0d want 0", err_cnt); end
   endtask

   task automatic test_word_errors;
      send(4'b0100, 1'b0); since_lock++;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", err); end
      n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL cnt_one: got %0d want 1", err_cnt); end
      n_checks++; if (sat_cnt !== 4'd1) begin n_fail++; $display("FAIL sat_cnt_one: got %0d want 1", sat_cnt); end
      data = 4'hF;
      @(posedge clk); #1;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clears_idle: got %b want 0", err); end
      n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL cnt_hold_idle: got %0d want 1", err_cnt); end
      send(4'h0, 1'b0); since_lock++;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clean_word: got %b want 0", err); end
      send(4'b0111, 1'b0); since_lock++;
      n_checks++; if (err_cnt !== 16'(EXP_TWO)) begin n_fail++; $display("FAIL cnt_second: got %0d want %0d", err_cnt, EXP_TWO); end
      n_checks++; if (sat_cnt !== 4'(EXP_TWO)) begin n_fail++; $display("FAIL sat_cnt_second: got %0d want %0d", sat_cnt, EXP_TWO); end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL still_locked: got %b want 1", locked); end
   endtask

   task automatic test_window_loss;
      while (since_lock % 256 != 0) begin
         send(4'h0, 1'b0);
         since_lock++;
      end
      // 31 errored words up front plus the window's final word: 32 in total.
      for (int w = 1; w <= 256; w++) begin
         send((w <= 31 || w == 256) ? 4'b0001 : 4'b0000, 1'b0);
         if (w == 31) begin
            n_checks++; if (sat_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold_15: got %0d want 15", sat_cnt); end
         end
         if (w == 255) begin
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_before_last: got %b want 1", locked); end
         end
      end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_on_last: got %b want 0", locked); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_on_loss_word: got %b want 1", err); end
      n_checks++; if (err_cnt !== 16'(EXP_LOSS)) begin n_fail++; $display("FAIL cnt_after_loss: got %0d want %0d", err_cnt, EXP_LOSS); end
      n_checks++; if (sat_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_after_loss: got %0d want 15", sat_cnt); end
      for (int w = 1; w <= 24; w++) begin
         send(4'h0, 1'b0);
         if (w == 23) begin
            n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b want 0", locked); end
         end
      end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_24: got %b want 1", locked); end
      since_lock = 0;
   endtask

   task automatic test_window_hold;
      // 30 errored words up front plus the final word: 31, one short of the threshold.
      for (int w = 1; w <= 257; w++) begin
         send((w <= 30 || w == 256) ? 4'b1000 : 4'b0000, 1'b0);
         since_lock++;
         if (w == 256) begin
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hold_31_last: got %b want 1", locked); end
         end
      end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hold_31_next: got %b want 1", locked); end
      n_checks++; if (err_cnt !== 16'(EXP_HOLD)) begin n_fail++; $display("FAIL cnt_after_hold: got %0d want %0d", err_cnt, EXP_HOLD); end
   endtask

   task automatic test_clear_priority;
      send(4'b0001, 1'b1);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL clr_err_pulse: got %b want 1", err); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_priority: got %0d want 0", err_cnt); end
      n_checks++; if (sat_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr_priority: got %0d want 0", sat_cnt); end
      send(4'b0011, 1'b0);
      n_checks++; if (err_cnt !== 16'(EXP_AFTER_CLR)) begin n_fail++; $display("FAIL cnt_after_clr: got %0d want %0d", err_cnt, EXP_AFTER_CLR); end
   endtask

   task automatic test_verify_error;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b want 0", locked); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", err_cnt); end
      for (int w = 1; w <= 44; w++) begin
         send((w == 20) ? 4'b1000 : 4'b0000, 1'b0);
         if (w == 24 || w == 43) begin
            n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL verify_no_lock_%0d: got %b want 0", w, locked); end
         end
      end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL verify_lock_44: got %b want 1", locked); end
   endtask

   task automatic test_start_and_reset;
      for (int w = 1; w <= 93; w++) begin
         ssend(w == 80);
         if (w == 20) begin
            n_checks++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL small_no_lock_20: got %b want 0", s_locked); end
         end
         if (w == 21) begin
            n_checks++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL small_lock_21: got %b want 1", s_locked); end
         end
         n_checks++;
         if (s_start !== ((w > 21) && (w % 31 == 0))) begin
            n_fail++; $display("FAIL start_word_%0d: got %b want %b", w, s_start, (w > 21) && (w % 31 == 0));
         end
      end
      n_checks++; if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL small_cnt: got %0d want 1", s_cnt); end
      s_rst = 1'b1;
      @(posedge clk); #1;
      s_rst = 1'b0;
      n_checks++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b want 0", s_locked); end
      n_checks++; if (s_start !== 1'b0) begin n_fail++; $display("FAIL midrst_start: got %b want 0", s_start); end
      n_checks++; if (s_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", s_cnt); end
      for (int w = 1; w <= 21; w++) begin
         ssend(1'b0);
         if (w == 20) begin
            n_checks++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL small_reacq_20: got %b want 0", s_locked); end
         end
      end
      n_checks++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL small_reacq_21: got %b want 1", s_locked); end
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_word_errors();
      test_window_loss();
      test_window_hold();
      test_clear_priority();
      test_verify_error();
      test_start_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
